// File: rtl/costas_pkg.sv
// Shared helpers and default widths for the Costas carrier-recovery blocks
// (error selector, loop filter, NCO wrappers).
package costas_pkg;

  localparam int COSTAS_WIDTH     = 16;
  localparam int COSTAS_ACC_WIDTH = 32;

  // Wide enough for ACC_WIDTH+2 headroom on any ACC_WIDTH up to 62.
  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  typedef enum logic {
    MODE_QPSK = 1'b0,
    MODE_BPSK = 1'b1
  } mode_e;

  function automatic calc_t clamp(calc_t x, calc_t lo, calc_t hi);
    calc_t r;
    r = x;
    if (x < lo) r = lo;
    else if (x > hi) r = hi;
    return r;
  endfunction

  function automatic calc_t sat_add(calc_t a, calc_t b, int w);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    lo = -hi - calc_t'(1);
    return clamp(a + b, lo, hi);
  endfunction

  // The most-negative w-bit code has no positive twin; report it as 2**(w-1).
  function automatic calc_t abs_mag(calc_t x, int w);
    calc_t most_neg;
    calc_t r;
    most_neg = -(calc_t'(1) <<< (w - 1));
    if (x == most_neg) r = calc_t'(1) <<< (w - 1);
    else if (x[CALC_W-1]) r = -x;
    else r = x;
    return r;
  endfunction

endpackage

// File: rtl/costas_loop_filter_if.sv
// Error-sample input and frequency-word output bundle of the Costas loop filter.
interface costas_loop_filter_if
  import costas_pkg::*;
#(
  parameter int WIDTH     = COSTAS_WIDTH,
  parameter int ACC_WIDTH = COSTAS_ACC_WIDTH
);

  logic                        is_bpsk;
  logic signed [WIDTH-1:0]     error_tdata;
  logic                        error_tvalid;
  logic signed [ACC_WIDTH-1:0] freq_tdata;
  logic                        freq_tvalid;
  logic                        locked;

  modport master (
    output is_bpsk, error_tdata, error_tvalid,
    input  freq_tdata, freq_tvalid, locked
  );

  modport slave (
    input  is_bpsk, error_tdata, error_tvalid,
    output freq_tdata, freq_tvalid, locked
  );

endinterface

// File: rtl/costas_lock_detect.sv
// Consecutive in-threshold sample counter; flags lock once LOCK_COUNT
// small-error samples arrive without an out-of-threshold one in between.
module costas_lock_detect
  import costas_pkg::*;
#(
  parameter int WIDTH       = COSTAS_WIDTH,
  parameter int LOCK_THRESH = 512,
  parameter int LOCK_COUNT  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] error,
  output logic                    locked
);

  localparam int                CNT_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_COUNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic             in_lock;

  // Idle cycles hold the count, so gaps between samples do not break lock.
  always_comb begin
    in_lock  = abs_mag(calc_t'(error), WIDTH) < calc_t'(LOCK_THRESH);
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (clear) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (sample_valid) begin
      if (in_lock) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      else         cnt_d = '0;
      locked_d = (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/costas_loop_filter.sv
// Proportional-integral loop filter for the Costas loop: turns phase error into
// an NCO frequency word through a two-stage pipeline with a clamped integrator.
module costas_loop_filter
  import costas_pkg::*;
#(
  parameter int     WIDTH       = COSTAS_WIDTH,
  parameter int     ACC_WIDTH   = COSTAS_ACC_WIDTH,
  parameter int     KP_SHIFT    = 4,
  parameter int     KI_SHIFT    = 0,
  parameter longint INTEG_LIMIT = 64'sd16777216,
  parameter longint FREQ_CENTER = 64'sd0,
  parameter int     LOCK_THRESH = 512,
  parameter int     LOCK_COUNT  = 64
) (
  input logic clk,
  input logic rst_n,
  costas_loop_filter_if.slave bus
);

  mode_e                       mode_q, mode_d;
  logic                        toggle;
  logic                        take;
  calc_t                       err_ext;
  logic signed [ACC_WIDTH-1:0] p_q, p_d;
  logic signed [ACC_WIDTH-1:0] integ_q, integ_d;
  logic signed [ACC_WIDTH-1:0] freq_q, freq_d;
  logic                        v1_q, v1_d;
  logic                        fv_q, fv_d;

  // A mode change flushes the integrator and drops the sample arriving with it.
  always_comb begin
    mode_d  = mode_e'(bus.is_bpsk);
    toggle  = bus.is_bpsk != logic'(mode_q);
    take    = bus.error_tvalid && !toggle;
    err_ext = calc_t'(bus.error_tdata);
    p_d     = p_q;
    integ_d = integ_q;
    v1_d    = take;
    if (toggle) begin
      integ_d = '0;
    end else if (take) begin
      p_d     = ACC_WIDTH'(err_ext <<< KP_SHIFT);
      integ_d = ACC_WIDTH'(clamp(calc_t'(integ_q) + (err_ext <<< KI_SHIFT),
                                 -calc_t'(INTEG_LIMIT), calc_t'(INTEG_LIMIT)));
    end

    // Stage 2 sees the integrator already updated by the same sample.
    freq_d = freq_q;
    fv_d   = v1_q;
    if (v1_q)
      freq_d = ACC_WIDTH'(sat_add(calc_t'(FREQ_CENTER) + calc_t'(p_q),
                                  calc_t'(integ_q), ACC_WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_BPSK;
      p_q     <= '0;
      integ_q <= '0;
      freq_q  <= ACC_WIDTH'(FREQ_CENTER);
      v1_q    <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      p_q     <= p_d;
      integ_q <= integ_d;
      freq_q  <= freq_d;
      v1_q    <= v1_d;
      fv_q    <= fv_d;
    end
  end

  costas_lock_detect #(
    .WIDTH       (WIDTH),
    .LOCK_THRESH (LOCK_THRESH),
    .LOCK_COUNT  (LOCK_COUNT)
  ) u_lock (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (toggle),
    .sample_valid (take),
    .error        (bus.error_tdata),
    .locked       (bus.locked)
  );

  assign bus.freq_tdata  = freq_q;
  assign bus.freq_tvalid = fv_q;

endmodule

// File: tb/tb_costas_loop_filter.sv
// Scoreboard bench: three filter instances share one random/directed stream,
// each checked against an arithmetic reference model of the loop filter.
module tb_costas_loop_filter;

  localparam int     N        = 3;
  localparam longint CENTER_A = 64'sd1000;
  localparam longint CENTER_B = 64'sd2147483548;
  localparam longint CENTER_C = -64'sd2147483598;
  localparam longint LIMIT_A  = 64'sd100;
  localparam longint LIMIT_BC = 64'sd16777216;

  localparam longint CENTER[N] = '{CENTER_A, CENTER_B, CENTER_C};
  localparam longint LIMIT[N]  = '{LIMIT_A, LIMIT_BC, LIMIT_BC};
  localparam int     THRESH[N] = '{8, 512, 512};
  localparam int     LCOUNT[N] = '{4, 64, 64};

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               is_bpsk = 1'b1;
  logic               err_v = 1'b0;
  logic signed [15:0] err = '0;

  always #5 clk = ~clk;

  costas_loop_filter_if #(.WIDTH(16), .ACC_WIDTH(32)) bus_a ();
  costas_loop_filter_if #(.WIDTH(16), .ACC_WIDTH(32)) bus_b ();
  costas_loop_filter_if #(.WIDTH(16), .ACC_WIDTH(32)) bus_c ();

  assign bus_a.is_bpsk = is_bpsk; assign bus_a.error_tvalid = err_v; assign bus_a.error_tdata = err;
  assign bus_b.is_bpsk = is_bpsk; assign bus_b.error_tvalid = err_v; assign bus_b.error_tdata = err;
  assign bus_c.is_bpsk = is_bpsk; assign bus_c.error_tvalid = err_v; assign bus_c.error_tdata = err;

  costas_loop_filter #(.WIDTH(16), .ACC_WIDTH(32), .KP_SHIFT(4), .KI_SHIFT(0),
    .INTEG_LIMIT(LIMIT_A), .FREQ_CENTER(CENTER_A), .LOCK_THRESH(8), .LOCK_COUNT(4))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  costas_loop_filter #(.WIDTH(16), .ACC_WIDTH(32), .KP_SHIFT(4), .KI_SHIFT(0),
    .INTEG_LIMIT(LIMIT_BC), .FREQ_CENTER(CENTER_B), .LOCK_THRESH(512), .LOCK_COUNT(64))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  costas_loop_filter #(.WIDTH(16), .ACC_WIDTH(32), .KP_SHIFT(4), .KI_SHIFT(0),
    .INTEG_LIMIT(LIMIT_BC), .FREQ_CENTER(CENTER_C), .LOCK_THRESH(512), .LOCK_COUNT(64))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  wire signed [31:0] freq_w[N];
  wire               fv_w[N];
  wire               lk_w[N];
  assign freq_w[0] = bus_a.freq_tdata; assign fv_w[0] = bus_a.freq_tvalid; assign lk_w[0] = bus_a.locked;
  assign freq_w[1] = bus_b.freq_tdata; assign fv_w[1] = bus_b.freq_tvalid; assign lk_w[1] = bus_b.locked;
  assign freq_w[2] = bus_c.freq_tdata; assign fv_w[2] = bus_c.freq_tvalid; assign lk_w[2] = bus_c.locked;

  typedef struct {
    longint val;
    int     due;
  } exp_t;

  exp_t   exp_q[N][$];
  longint m_integ[N];
  int     m_cnt[N];
  bit     m_locked[N];
  bit     m_mode;
  int     cyc = 0;
  longint held[N] = '{CENTER_A, CENTER_B, CENTER_C};
  int     compared = 0;
  int     mismatched = 0;

  task automatic check_output(input string name, input int idx, input longint act, input longint expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("[TB] FAIL %s[dut %0d] at cycle %0d: got %0d, expected %0d", name, idx, cyc, act, expv);
    end
  endtask

  task automatic report_fail(input string name, input int idx);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s[dut %0d] at cycle %0d", name, idx, cyc);
  endtask

  function automatic longint sat32(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  // Reference model: integrator, output word and lock count in plain arithmetic.
  always @(posedge clk or negedge rst_n) begin
    longint e, ni, mag;
    int     nc;
    if (!rst_n) begin
      m_mode <= 1'b1;
      for (int i = 0; i < N; i++) begin
        m_integ[i]  <= 0;
        m_cnt[i]    <= 0;
        m_locked[i] <= 1'b0;
        exp_q[i].delete();
      end
    end else begin
      cyc    <= cyc + 1;
      m_mode <= is_bpsk;
      if (is_bpsk != m_mode) begin
        for (int i = 0; i < N; i++) begin
          m_integ[i]  <= 0;
          m_cnt[i]    <= 0;
          m_locked[i] <= 1'b0;
        end
      end else if (err_v) begin
        e   = longint'(err);
        mag = (e < 0) ? -e : e;
        for (int i = 0; i < N; i++) begin
          ni = m_integ[i] + e;
          if (ni > LIMIT[i]) ni = LIMIT[i];
          if (ni < -LIMIT[i]) ni = -LIMIT[i];
          m_integ[i] <= ni;
          exp_q[i].push_back('{sat32(CENTER[i] + e * 16 + ni), cyc + 2});
          nc = (mag < THRESH[i]) ? ((m_cnt[i] + 1 > LCOUNT[i]) ? LCOUNT[i] : m_cnt[i] + 1) : 0;
          m_cnt[i]    <= nc;
          m_locked[i] <= (nc == LCOUNT[i]);
        end
      end
    end
  end

  // Monitor: pops an expectation for every strobe, otherwise checks the hold.
  always @(negedge clk) begin
    exp_t ex;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        check_output("reset_freq", i, longint'(freq_w[i]), CENTER[i]);
        check_output("reset_valid", i, longint'(fv_w[i]), 0);
        check_output("reset_locked", i, longint'(lk_w[i]), 0);
        held[i] = CENTER[i];
      end else begin
        if (fv_w[i]) begin
          if (exp_q[i].size() == 0) begin
            report_fail("unexpected_strobe", i);
          end else begin
            ex = exp_q[i].pop_front();
            check_output("strobe_cycle", i, longint'(cyc), longint'(ex.due));
            check_output("freq", i, longint'(freq_w[i]), ex.val);
            held[i] = ex.val;
          end
        end else begin
          check_output("held_freq", i, longint'(freq_w[i]), held[i]);
          if (exp_q[i].size() != 0 && exp_q[i][0].due <= cyc) begin
            report_fail("missed_strobe", i);
            void'(exp_q[i].pop_front());
          end
        end
        check_output("locked", i, longint'(lk_w[i]), longint'(m_locked[i]));
      end
    end
  end

  task automatic apply_stimulus(input bit bpsk, input bit v, input logic signed [15:0] e);
    @(negedge clk);
    #1;
    is_bpsk = bpsk;
    err_v   = v;
    err     = e;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) apply_stimulus(is_bpsk, 1'b0, 16'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    is_bpsk = 1'b1;
    err_v   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic signed [15:0] e;
    bit                 b;
    int                 r;

    $display("[TB] reset with random inputs");
    repeat (5) apply_stimulus(1'($urandom), 1'($urandom), 16'($urandom));
    check_output("reset_hold_freq", 0, longint'(freq_w[0]), CENTER_A);
    check_output("reset_hold_locked", 0, longint'(lk_w[0]), 0);
    @(negedge clk);
    #1;
    is_bpsk = 1'b1;
    err_v   = 1'b0;
    rst_n   = 1'b1;
    idle_cycles(10);

    $display("[TB] single sample");
    apply_stimulus(1'b1, 1'b1, 16'sd10);
    idle_cycles(4);
    check_output("single_sample", 0, longint'(freq_w[0]), 1170);

    $display("[TB] integrator clamp");
    do_reset();
    repeat (4) apply_stimulus(1'b1, 1'b1, 16'sd40);
    apply_stimulus(1'b1, 1'b1, -16'sd40);
    idle_cycles(3);
    check_output("clamp_recover", 0, longint'(freq_w[0]), 420);

    $display("[TB] mode toggle");
    do_reset();
    repeat (2) apply_stimulus(1'b1, 1'b1, 16'sd40);
    apply_stimulus(1'b0, 1'b1, 16'sd40);
    apply_stimulus(1'b0, 1'b1, 16'sd0);
    idle_cycles(3);
    check_output("toggle_flush", 0, longint'(freq_w[0]), CENTER_A);
    check_output("toggle_locked", 0, longint'(lk_w[0]), 0);

    $display("[TB] lock detector");
    do_reset();
    apply_stimulus(1'b1, 1'b1, 16'sd3);
    apply_stimulus(1'b1, 1'b1, -16'sd5);
    apply_stimulus(1'b1, 1'b1, 16'sd7);
    apply_stimulus(1'b1, 1'b1, 16'sd2);
    idle_cycles(1);
    check_output("lock_rise", 0, longint'(lk_w[0]), 1);
    apply_stimulus(1'b1, 1'b1, 16'sd8);
    idle_cycles(1);
    check_output("lock_fall_thresh", 0, longint'(lk_w[0]), 0);
    repeat (4) apply_stimulus(1'b1, 1'b1, 16'sd1);
    apply_stimulus(1'b1, 1'b1, -16'sd32768);
    idle_cycles(1);
    check_output("lock_fall_mostneg", 0, longint'(lk_w[0]), 0);
    repeat (3) apply_stimulus(1'b1, 1'b1, -16'sd7);
    idle_cycles(3);
    apply_stimulus(1'b1, 1'b1, 16'sd0);
    idle_cycles(1);
    check_output("lock_across_gap", 0, longint'(lk_w[0]), 1);

    $display("[TB] saturation");
    apply_stimulus(1'b1, 1'b1, 16'sd32767);
    idle_cycles(3);
    check_output("sat_pos", 1, longint'(freq_w[1]), 64'sd2147483647);
    apply_stimulus(1'b1, 1'b1, -16'sd32768);
    idle_cycles(3);
    check_output("sat_neg", 2, longint'(freq_w[2]), -64'sd2147483648);

    $display("[TB] reset between stages");
    do_reset();
    apply_stimulus(1'b1, 1'b1, 16'sd50);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    err_v = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b1, 16'sd0);
    idle_cycles(3);
    check_output("reset_mid_flush", 0, longint'(freq_w[0]), CENTER_A);

    $display("[TB] random traffic");
    for (int k = 0; k < 600; k++) begin
      b = is_bpsk;
      if ($urandom_range(0, 49) == 0) b = !b;
      r = int'($urandom_range(0, 9));
      if (r < 7)       e = 16'(int'($urandom_range(0, 20)) - 10);
      else if (r < 9)  e = 16'($urandom);
      else             e = ($urandom_range(0, 1) == 0) ? 16'sh7fff : 16'sh8000;
      apply_stimulus(b, $urandom_range(0, 3) != 0, e);
    end
    idle_cycles(5);
    for (int i = 0; i < N; i++)
      check_output("queue_drained", i, longint'(exp_q[i].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
